output_gain_limiter: RTL and testbench

Sits between the two harmonic accumulators and the DAC serialiser. Each sample frame it takes the latched 32-bit odd/even accumulator totals (L/R). It pre-shifts them, multiplies by a slowly varying gain, then saturates each channel to signed 16 bits for the DAC. An automatic gain stage lowers the gain when output clips and slowly restores it, so dense harmonic settings do not hard-clip continuously.

---
 rtl/addatone_pkg.sv | 36 +++
 rtl/serial_mult.sv | 57 +++++
 rtl/output_gain_limiter.sv | 179 +++++++++++++++++
 tb/tb_output_gain_limiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/addatone_pkg.sv
// Shared constants, FSM encoding and saturation helper for the output stage
// (Q4.12 gain, 16-bit DAC samples, 24-bit pre-scaled operands, 40-bit products).
package addatone_pkg;

    localparam int GAIN_W    = 16;
    localparam int GAIN_FRAC = 12;
    localparam int DAC_W     = 16;
    localparam int ACC_W     = 32;
    localparam int PRE_W     = 24;
    localparam int PROD_W    = 40;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_SAT  = 2'd2,
        ST_AGC  = 2'd3
    } state_t;

    // Clamp a signed value to the signed range of 'bits' bits.
    function automatic logic signed [PROD_W-1:0] sat(input logic signed [PROD_W-1:0] v,
                                                      input int bits);
        logic signed [PROD_W-1:0] one;
        logic signed [PROD_W-1:0] hi;
        logic signed [PROD_W-1:0] lo;
        one = 1;
        hi  = (one <<< (bits - 1)) - one;
        lo  = -(one <<< (bits - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/serial_mult.sv
// Shift-add multiplier: signed 24-bit operand times unsigned 16-bit gain,
// one partial product per clock, o_Done pulses 16 cycles after i_Start.
module serial_mult
    import addatone_pkg::*;
(
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Start,
    input  logic [PRE_W-1:0]  i_A,
    input  logic [GAIN_W-1:0] i_B,
    output logic              o_Done,
    output logic [PROD_W-1:0] o_Product
);

    logic signed [PROD_W-1:0] r_mcand;
    logic [GAIN_W-1:0]        r_mplier;
    logic signed [PROD_W-1:0] r_acc;
    logic [3:0]               r_cnt;
    logic                     r_run;
    logic                     r_done;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
            r_done   <= 1'b0;
        end else if (i_Start) begin
            r_mcand  <= PROD_W'($signed(i_A));
            r_mplier <= i_B;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b1;
            r_done   <= 1'b0;
        end else if (r_run) begin
            // The multiplier is unsigned, so no correction term is needed for bit 15.
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand <<< 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
                r_run  <= 1'b0;
                r_done <= 1'b1;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_Done    = r_done;
    assign o_Product = r_acc;

endmodule

// File: rtl/output_gain_limiter.sv
// Per-frame pre-shift, gain multiply and 16-bit saturation of the L/R accumulator totals.
// Define OUTPUT_AGC_EN to enable automatic gain reduction on clip and slow release.
module output_gain_limiter
    import addatone_pkg::*;
#(
    parameter int PRE_SHIFT       = 6,
    parameter int GAIN_UNITY      = 4096
`ifdef OUTPUT_AGC_EN
    ,
    parameter int GAIN_MIN        = 256,
    parameter int ATTACK_SHIFT    = 4,
    parameter int RELEASE_SAMPLES = 48,
    parameter int RELEASE_STEP    = 16
`endif
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Start,
    input  logic [ACC_W-1:0]  i_Sample_L,
    input  logic [ACC_W-1:0]  i_Sample_R,
    output logic [DAC_W-1:0]  o_Sample_L,
    output logic [DAC_W-1:0]  o_Sample_R,
    output logic              o_Valid,
    output logic              o_Busy,
    output logic              o_Clip,
    output logic [GAIN_W-1:0] o_Gain
);

    // Handshake: i_Start is accepted only in IDLE; o_Busy stays high from the accepting
    // edge through the o_Valid cycle, so a start coincident with o_Valid is dropped.

    localparam logic [GAIN_W-1:0] L_GAIN_UNITY = GAIN_W'(GAIN_UNITY);

    state_t r_state;
    state_t w_next;
    logic   w_mult_start;
    logic   w_valid;

    logic [GAIN_W-1:0]        w_gain;
    logic signed [PROD_W-1:0] w_ext_l, w_ext_r;
    logic [PRE_W-1:0]         w_pre_l, w_pre_r;
    logic                     w_pre_clip_l, w_pre_clip_r;
    logic                     w_done_l, w_done_r;
    logic signed [PROD_W-1:0] w_prod_l, w_prod_r;
    logic signed [PROD_W-1:0] w_scaled_l, w_scaled_r;
    logic [DAC_W-1:0]         w_out_l, w_out_r;
    logic                     w_sat_clip_l, w_sat_clip_r;

    logic             r_clip_l, r_clip_r;
    logic [DAC_W-1:0] r_out_l, r_out_r;

    assign w_ext_l      = PROD_W'($signed(i_Sample_L) >>> PRE_SHIFT);
    assign w_ext_r      = PROD_W'($signed(i_Sample_R) >>> PRE_SHIFT);
    assign w_pre_l      = PRE_W'(sat(w_ext_l, PRE_W));
    assign w_pre_r      = PRE_W'(sat(w_ext_r, PRE_W));
    assign w_pre_clip_l = (PROD_W'($signed(w_pre_l)) != w_ext_l);
    assign w_pre_clip_r = (PROD_W'($signed(w_pre_r)) != w_ext_r);

    serial_mult u_mult_l (
        .i_Clock  (i_Clock),
        .i_Reset  (i_Reset),
        .i_Start  (w_mult_start),
        .i_A      (w_pre_l),
        .i_B      (w_gain),
        .o_Done   (w_done_l),
        .o_Product(w_prod_l)
    );

    serial_mult u_mult_r (
        .i_Clock  (i_Clock),
        .i_Reset  (i_Reset),
        .i_Start  (w_mult_start),
        .i_A      (w_pre_r),
        .i_B      (w_gain),
        .o_Done   (w_done_r),
        .o_Product(w_prod_r)
    );

    // Floor division by 4096 via arithmetic shift, then clamp to the DAC range.
    assign w_scaled_l   = w_prod_l >>> GAIN_FRAC;
    assign w_scaled_r   = w_prod_r >>> GAIN_FRAC;
    assign w_out_l      = DAC_W'(sat(w_scaled_l, DAC_W));
    assign w_out_r      = DAC_W'(sat(w_scaled_r, DAC_W));
    assign w_sat_clip_l = (PROD_W'($signed(w_out_l)) != w_scaled_l);
    assign w_sat_clip_r = (PROD_W'($signed(w_out_r)) != w_scaled_r);

    always_comb begin
        w_next       = r_state;
        w_mult_start = 1'b0;
        w_valid      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_Start) begin
                    w_next       = ST_MULT;
                    w_mult_start = 1'b1;
                end
            end
            ST_MULT: begin
                if (w_done_l && w_done_r) begin
                    w_next = ST_SAT;
                end
            end
            ST_SAT: begin
                w_next = ST_AGC;
            end
            ST_AGC: begin
                w_next  = ST_IDLE;
                w_valid = 1'b1;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state  <= ST_IDLE;
            r_clip_l <= 1'b0;
            r_clip_r <= 1'b0;
            r_out_l  <= '0;
            r_out_r  <= '0;
        end else begin
            r_state <= w_next;
            if (w_mult_start) begin
                r_clip_l <= w_pre_clip_l;
                r_clip_r <= w_pre_clip_r;
            end
            if (r_state == ST_SAT) begin
                r_out_l  <= w_out_l;
                r_out_r  <= w_out_r;
                r_clip_l <= r_clip_l | w_sat_clip_l;
                r_clip_r <= r_clip_r | w_sat_clip_r;
            end
        end
    end

`ifdef OUTPUT_AGC_EN
    localparam int                CNT_W      = $clog2(RELEASE_SAMPLES + 1);
    localparam logic [GAIN_W-1:0] L_GAIN_MIN = GAIN_W'(GAIN_MIN);
    localparam logic [GAIN_W-1:0] L_STEP     = GAIN_W'(RELEASE_STEP);

    logic [GAIN_W-1:0] r_gain;
    logic [GAIN_W-1:0] w_attack_gain;
    logic [CNT_W-1:0]  r_rel_cnt;

    assign w_attack_gain = r_gain - (r_gain >> ATTACK_SHIFT);

    // Gain only moves in the AGC cycle, so a running multiply always sees a stable G.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_gain    <= L_GAIN_UNITY;
            r_rel_cnt <= '0;
        end else if (r_state == ST_AGC) begin
            if (r_clip_l || r_clip_r) begin
                r_gain    <= (w_attack_gain < L_GAIN_MIN) ? L_GAIN_MIN : w_attack_gain;
                r_rel_cnt <= '0;
            end else if (r_rel_cnt == CNT_W'(RELEASE_SAMPLES - 1)) begin
                r_gain    <= (r_gain > L_GAIN_UNITY - L_STEP) ? L_GAIN_UNITY : r_gain + L_STEP;
                r_rel_cnt <= '0;
            end else begin
                r_rel_cnt <= r_rel_cnt + CNT_W'(1);
            end
        end
    end

    assign w_gain = r_gain;
`else
    assign w_gain = L_GAIN_UNITY;
`endif

    assign o_Sample_L = r_out_l;
    assign o_Sample_R = r_out_r;
    assign o_Valid    = w_valid;
    assign o_Clip     = w_valid & (r_clip_l | r_clip_r);
    assign o_Busy     = (r_state != ST_IDLE);
    assign o_Gain     = w_gain;

endmodule

// File: tb/tb_output_gain_limiter.sv
// Directed bench for output_gain_limiter; expected gain values follow OUTPUT_AGC_EN.
module tb_output_gain_limiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] in_l = '0;
    logic [31:0] in_r = '0;
    logic [15:0] out_l, out_r, gain;
    logic        valid, busy, clip;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_gain = 4096;
    int exp_cnt  = 0;
    logic [32:0] exp_q[$];

`ifdef OUTPUT_AGC_EN
    localparam int G_AFTER_CLIP = 3840;
    localparam int G_AFTER_48   = 3856;
    localparam int G_FLOOR      = 256;
`else
    localparam int G_AFTER_CLIP = 4096;
    localparam int G_AFTER_48   = 4096;
    localparam int G_FLOOR      = 4096;
`endif

    output_gain_limiter dut (
        .i_Clock   (clk),
        .i_Reset   (rst),
        .i_Start   (start),
        .i_Sample_L(in_l),
        .i_Sample_R(in_r),
        .o_Sample_L(out_l),
        .o_Sample_R(out_r),
        .o_Valid   (valid),
        .o_Busy    (busy),
        .o_Clip    (clip),
        .o_Gain    (gain)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_gain = 4096;
        exp_cnt  = 0;
    endtask

    // Reference gain update after one frame.
    task automatic model_agc(input logic frame_clip);
`ifdef OUTPUT_AGC_EN
        if (frame_clip) begin
            exp_gain = exp_gain - (exp_gain >> 4);
            if (exp_gain < 256) exp_gain = 256;
            exp_cnt = 0;
        end else begin
            exp_cnt++;
            if (exp_cnt == 48) begin
                exp_gain = exp_gain + 16;
                if (exp_gain > 4096) exp_gain = 4096;
                exp_cnt = 0;
            end
        end
`else
        exp_cnt = frame_clip ? 0 : exp_cnt;
`endif
    endtask

    // Wait for o_Valid, counting rising edges after the accepting edge.
    task automatic wait_valid(output int lat, output logic got);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 1000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (valid) got = 1'b1;
        end
    endtask

    task automatic check_frame_outputs(input logic got);
        logic [32:0] e;
        check_val("valid_seen", 32'(got), 32'd1);
        e = exp_q.pop_front();
        check_val("out_l", 32'($signed(out_l)), 32'($signed(e[31:16])));
        check_val("out_r", 32'($signed(out_r)), 32'($signed(e[15:0])));
        check_val("clip", 32'(clip), 32'(e[32]));
        check_val("busy_at_valid", 32'(busy), 32'd1);
        model_agc(e[32]);
        @(posedge clk);
        @(negedge clk);
        check_val("valid_pulse_len", 32'(valid), 32'd0);
        check_val("busy_after", 32'(busy), 32'd0);
        check_val("gain", 32'(gain), 32'(exp_gain));
    endtask

    task automatic run_frame(input logic [31:0] l, input logic [31:0] r,
                             input int el, input int er, input logic ec, output int lat);
        logic got;
        exp_q.push_back({ec, 16'(el), 16'(er)});
        @(negedge clk);
        in_l  = l;
        in_r  = r;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_valid(lat, got);
        check_frame_outputs(got);
    endtask

    initial begin
        int lat;
        int extra;
        logic got;

        do_reset();
        check_val("rst_out_l", 32'(out_l), 32'd0);
        check_val("rst_out_r", 32'(out_r), 32'd0);
        check_val("rst_valid", 32'(valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_clip", 32'(clip), 32'd0);
        check_val("rst_gain", 32'(gain), 32'd4096);

        run_frame(32'h0001_0000, -32'sh0001_0000, 1024, -1024, 1'b0, lat);
        check_val("latency", 32'(lat), 32'd18);

        // A second start five cycles into a frame must not be relatched or counted.
        exp_q.push_back({1'b0, 16'd2048, 16'd3072});
        @(negedge clk);
        in_l = 32'h0002_0000;
        in_r = 32'h0003_0000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_val("busy_in_frame", 32'(busy), 32'd1);
        repeat (4) @(negedge clk);
        in_l = 32'h7FFF_FFFF;
        in_r = 32'h8000_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(lat, got);
        check_frame_outputs(got);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid) extra++;
        end
        check_val("no_extra_valid", 32'(extra), 32'd0);

        run_frame(32'h7FFF_FFFF, 32'h0, 32767, 0, 1'b1, lat);
        check_val("gain_after_clip", 32'(gain), 32'(G_AFTER_CLIP));

        for (int i = 0; i < 48; i++) run_frame(32'h0, 32'h0, 0, 0, 1'b0, lat);
        check_val("gain_after_48", 32'(gain), 32'(G_AFTER_48));
        for (int i = 48; i < 768; i++) run_frame(32'h0, 32'h0, 0, 0, 1'b0, lat);
        check_val("gain_after_768", 32'(gain), 32'd4096);

        for (int i = 0; i < 60; i++) run_frame(32'h8000_0000, 32'h0, -32768, 0, 1'b1, lat);
        check_val("gain_floor", 32'(gain), 32'(G_FLOOR));

        for (int i = 0; i < 10; i++) run_frame(32'h7FFF_FFFF, 32'h0, 32767, 0, 1'b1, lat);
        check_val("gain_floor_hold", 32'(gain), 32'(G_FLOOR));

        // Reset in the middle of the multiply aborts the frame.
        @(negedge clk);
        in_l = 32'h0001_0000;
        in_r = 32'h0001_0000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_gain = 4096;
        exp_cnt  = 0;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid) extra++;
        end
        check_val("abort_no_valid", 32'(extra), 32'd0);
        check_val("abort_out_l", 32'(out_l), 32'd0);
        check_val("abort_out_r", 32'(out_r), 32'd0);
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_gain", 32'(gain), 32'(exp_gain));

        run_frame(32'h0001_0000, -32'sh0001_0000, 1024, -1024, 1'b0, lat);
        check_val("latency_after_abort", 32'(lat), 32'd18);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
